rsa_mod_exp_core: RTL

Parametrised, handshaked modular exponentiation engine (result = base^exponent mod modulus) for the RSA datapath. It replaces the fixed-width, pulse-reset exponentiation stage in `control` with four things that stage lacks:
- independent modulus and exponent widths;
- a ready/start/done handshake that supports back-to-back operations;
- automatic reduction of bases at or above the modulus;
- an error flag for a zero modulus.

It sits between key setup (inverter) and message I/O. It is used for both encryption (exponent = e) and decryption (exponent = d).

---
 rtl/rsa_mod_exp_core_if.sv | 26 ++
 rtl/rsa_mod_exp_core.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rsa_mod_exp_core_if.sv
// Request/response bundle for the modular exponentiation engine.
// The master drives the operands and start; the slave returns the handshake, status and result.
interface rsa_mod_exp_core_if #(
    parameter int WIDTH     = 128,
    parameter int EXP_WIDTH = 128
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exponent;
    logic [WIDTH-1:0]     modulus;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [WIDTH-1:0]     result;

    modport master (
        output start, base, exponent, modulus,
        input  ready, busy, done, error, result
    );

    modport slave (
        input  start, base, exponent, modulus,
        output ready, busy, done, error, result
    );
endinterface

// File: rtl/rsa_mod_exp_core.sv
// base^exponent mod modulus by right-to-left square-and-multiply over a bit-serial modular multiplier.
// Latency WIDTH*(1+popcount(E)+bitlen(E)-1)+1 edges; start is only taken while ready, never queued.
module rsa_mod_exp_core #(
    parameter int WIDTH     = 128,
    parameter int EXP_WIDTH = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    rsa_mod_exp_core_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, REDUCE, MUL, SQR, FIN} state_t;

    state_t               state;
    logic [WIDTH-1:0]     m_reg;
    logic [WIDTH-1:0]     r_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     result_q;
    logic [EXP_WIDTH-1:0] e_reg;
    logic [EXP_WIDTH-1:0] e_shift;
    logic [WIDTH:0]       acc;
    logic [WIDTH:0]       dbl;
    logic [WIDTH:0]       dbl_red;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       sum_red;
    logic [WIDTH:0]       acc_next;
    logic [WIDTH-1:0]     prod;
    logic [CW-1:0]        cnt;
    logic                 last;
    logic                 m_zero;
    logic                 done_q;
    logic                 error_q;

    // acc stays below m, so each add/double is below 2m and one subtract restores the range
    always_comb begin
        dbl      = acc + acc;
        dbl_red  = (dbl >= {1'b0, m_reg}) ? dbl - {1'b0, m_reg} : dbl;
        sum      = dbl_red + {1'b0, mcand};
        sum_red  = (sum >= {1'b0, m_reg}) ? sum - {1'b0, m_reg} : sum;
        acc_next = mplier[WIDTH-1] ? sum_red : dbl_red;
    end

    assign prod    = acc_next[WIDTH-1:0];
    assign e_shift = e_reg >> 1;
    assign last    = (cnt == CW'(WIDTH - 1));

    assign bus.ready  = (state == IDLE);
    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.error  = error_q;
    assign bus.result = result_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            m_reg    <= '0;
            r_reg    <= '0;
            b_reg    <= '0;
            mcand    <= '0;
            mplier   <= '0;
            e_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            m_zero   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_reg   <= bus.modulus;
                        e_reg   <= bus.exponent;
                        error_q <= 1'b0;
                        acc     <= '0;
                        cnt     <= '0;
                        if (bus.modulus == '0) begin
                            m_zero <= 1'b1;
                            r_reg  <= '0;
                            state  <= FIN;
                        end else begin
                            // Reduction multiplies base by (1 mod m), base streamed as the multiplier
                            m_zero <= 1'b0;
                            r_reg  <= (bus.modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                            mcand  <= (bus.modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                            mplier <= bus.base;
                            state  <= REDUCE;
                        end
                    end
                end
                REDUCE, MUL, SQR: begin
                    acc    <= acc_next;
                    mplier <= mplier << 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        acc <= '0;
                        cnt <= '0;
                        if (state == MUL) begin
                            r_reg <= prod;
                            e_reg <= e_shift;
                            if (e_shift == '0) begin
                                state <= FIN;
                            end else begin
                                mplier <= b_reg;
                                mcand  <= b_reg;
                                state  <= SQR;
                            end
                        end else begin
                            b_reg <= prod;
                            if (e_reg == '0) begin
                                state <= FIN;
                            end else if (e_reg[0]) begin
                                mplier <= r_reg;
                                mcand  <= prod;
                                state  <= MUL;
                            end else begin
                                e_reg  <= e_shift;
                                mplier <= prod;
                                mcand  <= prod;
                                state  <= SQR;
                            end
                        end
                    end
                end
                FIN: begin
                    result_q <= r_reg;
                    done_q   <= 1'b1;
                    error_q  <= m_zero;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
